// File: rtl/mips_pkg.sv
// ============================================================================
//  mips_pkg -- opcodes, FSM state encoding and datapath control encodings.
//  Optional sub-word memory ops enabled by MC_CTRL_SUBWORD_EN. Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_BRSUB  = 3'b001;
  localparam logic [2:0] ALU_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_ANDI   = 3'b011;
  localparam logic [2:0] ALU_ORI    = 3'b100;
  localparam logic [2:0] ALU_SLTI   = 3'b101;
  localparam logic [2:0] ALU_SLTIU  = 3'b110;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LW: is_load = 1'b1;
`ifdef MC_CTRL_SUBWORD_EN
      OP_LB, OP_LH, OP_LBU, OP_LHU: is_load = 1'b1;
`endif
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SW: is_store = 1'b1;
`ifdef MC_CTRL_SUBWORD_EN
      OP_SB, OP_SH: is_store = 1'b1;
`endif
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_SLTI, OP_SLTIU, OP_LUI: is_imm = 1'b1;
      default:                   is_imm = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI:  imm_alu_op = ALU_ANDI;
      OP_ORI:   imm_alu_op = ALU_ORI;
      OP_SLTI:  imm_alu_op = ALU_SLTI;
      OP_SLTIU: imm_alu_op = ALU_SLTIU;
      default:  imm_alu_op = ALU_ADD;
    endcase
  endfunction

  // Without sub-word support every memory access is a signed word.
  function automatic logic [1:0] op_mem_size(input logic [5:0] op);
    op_mem_size = SIZE_WORD;
`ifdef MC_CTRL_SUBWORD_EN
    case (op)
      OP_LH, OP_LHU, OP_SH: op_mem_size = SIZE_HALF;
      OP_LB, OP_LBU, OP_SB: op_mem_size = SIZE_BYTE;
      default:              op_mem_size = SIZE_WORD;
    endcase
`else
    op_mem_size = (op == 6'b111111) ? SIZE_WORD : SIZE_WORD;
`endif
  endfunction

  function automatic logic op_mem_unsigned(input logic [5:0] op);
`ifdef MC_CTRL_SUBWORD_EN
    op_mem_unsigned = (op == OP_LBU) || (op == OP_LHU);
`else
    op_mem_unsigned = (op == 6'b111111) && 1'b0;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
//  mc_output_decode -- combinational state/opcode to datapath control decode.
//  Sub-word size fields depend on MC_CTRL_SUBWORD_EN (via mips_pkg). Rev 1.0
// ============================================================================
`default_nettype none

module mc_output_decode
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_ir_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_bne,
  output logic       o_lui,
  output logic       o_jal_link,
  output logic [1:0] o_mem_size,
  output logic       o_mem_unsigned,
  output logic       o_illegal_op
);

  logic w_legal;

  assign w_legal = is_load(i_opcode) || is_store(i_opcode) || is_imm(i_opcode) ||
                   (i_opcode == OP_RTYPE) || (i_opcode == OP_BEQ) ||
                   (i_opcode == OP_BNE) || (i_opcode == OP_J) || (i_opcode == OP_JAL);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_i_or_d        = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_REG;
    o_alu_op        = ALU_ADD;
    o_pc_source     = PCSRC_ALU;
    o_bne           = 1'b0;
    o_lui           = 1'b0;
    o_jal_link      = 1'b0;
    o_mem_size      = SIZE_WORD;
    o_mem_unsigned  = 1'b0;
    o_illegal_op    = 1'b0;
    case (i_state)
      S_FETCH: begin
        // IR load and PC+4 commit only on the cycle the fetch completes.
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b  = SRCB_IMM_SH2;
        o_illegal_op = !w_legal;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_mem_read     = 1'b1;
        o_i_or_d       = 1'b1;
        o_mem_size     = op_mem_size(i_opcode);
        o_mem_unsigned = op_mem_unsigned(i_opcode);
      end
      S_MEM_WB: begin
        o_reg_write    = 1'b1;
        o_mem_to_reg   = 1'b1;
        o_mem_size     = op_mem_size(i_opcode);
        o_mem_unsigned = op_mem_unsigned(i_opcode);
      end
      S_MEM_WR: begin
        o_mem_write    = 1'b1;
        o_i_or_d       = 1'b1;
        o_mem_size     = op_mem_size(i_opcode);
        o_mem_unsigned = op_mem_unsigned(i_opcode);
      end
      S_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = imm_alu_op(i_opcode);
        o_lui       = (i_opcode == OP_LUI);
      end
      S_I_WB: begin
        o_reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALU_BRSUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
        o_bne           = (i_opcode == OP_BNE);
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
      end
      S_JAL_WB: begin
        o_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
        o_reg_write = 1'b1;
        o_jal_link  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
//  mc_control_fsm -- multi-cycle MIPS control FSM (state register + next state).
//  Sub-word loads/stores enabled by MC_CTRL_SUBWORD_EN. Rev 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            bne,
  output logic            lui,
  output logic            jal_link,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic [ST_W-1:0] state,
  output logic            illegal_op
);

  generate
    if (ST_W < 4) begin : g_st_w_check
      $error("mc_control_fsm: ST_W must be at least 4");
    end
  endgenerate

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_load(opcode) || is_store(opcode)) w_next = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)             w_next = S_R_EXEC;
        else if (is_imm(opcode))                 w_next = S_I_EXEC;
        else if (opcode == OP_BEQ || opcode == OP_BNE) w_next = S_BRANCH;
        else if (opcode == OP_J)                 w_next = S_JUMP;
        else if (opcode == OP_JAL)               w_next = S_JAL_WB;
        else                                     w_next = S_FETCH;
      end
      S_MEM_ADDR: w_next = is_store(opcode) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  assign state = ST_W'(r_state);

  mc_output_decode u_decode (
    .i_state        (r_state),
    .i_opcode       (opcode),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_pc_write_cond(pc_write_cond),
    .o_i_or_d       (i_or_d),
    .o_ir_write     (ir_write),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_to_reg   (mem_to_reg),
    .o_reg_dst      (reg_dst),
    .o_reg_write    (reg_write),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_alu_op       (alu_op),
    .o_pc_source    (pc_source),
    .o_bne          (bne),
    .o_lui          (lui),
    .o_jal_link     (jal_link),
    .o_mem_size     (mem_size),
    .o_mem_unsigned (mem_unsigned),
    .o_illegal_op   (illegal_op)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
//  tb_mc_control_fsm -- self-checking bench with an instruction-level model.
//  Expectations follow MC_CTRL_SUBWORD_EN when it is defined. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4,
                 MEM_WR = 5, R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9,
                 BRANCH = 10, JUMP = 11, JAL_WB = 12;
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4,
                 C_J = 5, C_JAL = 6, C_ILL = 7;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       bne, lui, jal_link;
    logic [1:0] mem_size;
    logic       mem_unsigned, illegal_op;
    logic [3:0] state;
  } ctl_t;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, bne, lui, jal_link;
  logic       mem_unsigned, illegal_op;
  logic [1:0] alu_src_b, pc_source, mem_size;
  logic [2:0] alu_op;
  logic [3:0] state;
  ctl_t       got, exp;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.ST_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .bne(bne), .lui(lui), .jal_link(jal_link),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .state(state),
    .illegal_op(illegal_op)
  );

  assign got = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, bne, lui, jal_link, mem_size, mem_unsigned,
                illegal_op, state};

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b100011: return C_LOAD;
      6'b101011: return C_STORE;
`ifdef MC_CTRL_SUBWORD_EN
      6'b100000, 6'b100001, 6'b100100, 6'b100101: return C_LOAD;
      6'b101000, 6'b101001: return C_STORE;
`endif
      6'b000000: return C_R;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001111: return C_I;
      6'b000100, 6'b000101: return C_BR;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic iq_t path_of(input logic [5:0] op);
    case (cls(op))
      C_LOAD:  return '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB};
      C_STORE: return '{FETCH, DECODE, MEM_ADDR, MEM_WR};
      C_R:     return '{FETCH, DECODE, R_EXEC, R_WB};
      C_I:     return '{FETCH, DECODE, I_EXEC, I_WB};
      C_BR:    return '{FETCH, DECODE, BRANCH};
      C_J:     return '{FETCH, DECODE, JUMP};
      C_JAL:   return '{FETCH, DECODE, JAL_WB};
      default: return '{FETCH, DECODE};
    endcase
  endfunction

  function automatic bit op_used(input int st);
    return st == DECODE || st == MEM_ADDR || st == MEM_RD || st == MEM_WB ||
           st == MEM_WR || st == I_EXEC || st == BRANCH;
  endfunction

  // Reference control word for a state given the opcode and mem_ready seen.
  function automatic ctl_t exp_out(input int st, input logic [5:0] op, input logic rdy);
    ctl_t o;
    logic [1:0] sz;
    logic       un;
    o = '0;
    o.state = 4'(st);
    sz = 2'b00;
    un = 1'b0;
`ifdef MC_CTRL_SUBWORD_EN
    if (op == 6'b100001 || op == 6'b100101 || op == 6'b101001) sz = 2'b01;
    if (op == 6'b100000 || op == 6'b100100 || op == 6'b101000) sz = 2'b10;
    un = (op == 6'b100100 || op == 6'b100101);
`endif
    case (st)
      FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      DECODE:   begin o.alu_src_b = 2'b11; o.illegal_op = (cls(op) == C_ILL); end
      MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      MEM_RD:   begin o.mem_read = 1; o.i_or_d = 1; o.mem_size = sz; o.mem_unsigned = un; end
      MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; o.mem_size = sz; o.mem_unsigned = un; end
      MEM_WR:   begin o.mem_write = 1; o.i_or_d = 1; o.mem_size = sz; o.mem_unsigned = un; end
      R_EXEC:   begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      R_WB:     begin o.reg_write = 1; o.reg_dst = 1; end
      I_EXEC: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10; o.lui = (op == 6'b001111);
        case (op)
          6'b001100: o.alu_op = 3'b011;
          6'b001101: o.alu_op = 3'b100;
          6'b001010: o.alu_op = 3'b101;
          6'b001011: o.alu_op = 3'b110;
          default:   o.alu_op = 3'b000;
        endcase
      end
      I_WB:     o.reg_write = 1;
      BRANCH:   begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1;
                      o.pc_source = 2'b01; o.bne = (op == 6'b000101); end
      JUMP:     begin o.pc_write = 1; o.pc_source = 2'b10; end
      JAL_WB:   begin o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1; o.jal_link = 1; end
      default:  ;
    endcase
    return o;
  endfunction

  // Walks one instruction from FETCH; fw/mw are mem_ready stall cycles.
  task automatic test_instruction(input logic [5:0] op, input int fw, input int mw);
    iq_t path;
    path = path_of(op);
    foreach (path[k]) begin
      int st;
      int ncyc;
      st = path[k];
      ncyc = (st == FETCH) ? fw + 1 : ((st == MEM_RD || st == MEM_WR) ? mw + 1 : 1);
      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        opcode = op_used(st) ? op : 6'($urandom);
        if (st == FETCH || st == MEM_RD || st == MEM_WR) mem_ready = (c == ncyc - 1);
        else mem_ready = 1'($urandom);
        #1;
        exp = exp_out(st, opcode, mem_ready);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL ctl op=%b st=%0d cyc=%0d: got %h expected %h", op, st, c, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (got !== exp_out(FETCH, opcode, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", got, exp_out(FETCH, opcode, 1'b0));
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got state=%0d illegal=%b expected state=0 illegal=0", state, illegal_op);
    end
  endtask

  task automatic test_back_to_fetch(input string name);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_return: got state=%0d illegal=%b expected state=0 illegal=0", name, state, illegal_op);
    end
  endtask

  task automatic test_directed;
    test_instruction(6'b000000, 0, 0); test_back_to_fetch("add");
    test_instruction(6'b100011, 1, 3); test_back_to_fetch("lw");
    test_instruction(6'b000101, 0, 0); test_back_to_fetch("bne");
    test_instruction(6'b000011, 2, 0); test_back_to_fetch("jal");
    test_instruction(6'b111111, 0, 0); test_back_to_fetch("illegal");
    test_instruction(6'b100100, 0, 1); test_back_to_fetch("lbu");
    test_instruction(6'b101001, 0, 2); test_back_to_fetch("sh");
    test_instruction(6'b001111, 0, 0); test_back_to_fetch("lui");
  endtask

  task automatic test_reset_mid_write;
    int         sts[4]  = '{FETCH, DECODE, MEM_ADDR, MEM_WR};
    logic [5:0] op      = 6'b101011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      opcode = op;
      mem_ready = (k == 0);
      #1;
      exp = exp_out(sts[(k < 4) ? k : 3], opcode, mem_ready);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL sw_wait cyc=%0d: got %h expected %h", k, got, exp);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp = exp_out(FETCH, opcode, 1'b0);
    vectors++;
    if (got !== exp || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_write: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_random;
    logic [5:0] ops[21] = '{6'h00, 6'h23, 6'h2b, 6'h20, 6'h21, 6'h24, 6'h25,
                            6'h28, 6'h29, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                            6'h0d, 6'h0f, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 20)];
      test_instruction(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_reset_mid_write;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
